// File: rtl/serial_shifter_pkg.sv
// serial_shifter_pkg: shared constants and types for the serial shift unit.
// Optional feature macro used by this slice: SERIAL_SHIFTER_ROTATE_EN.
package serial_shifter_pkg;

    // Default operand width of the shift unit.
    localparam int SHIFTER_WIDTH = 32;

    // Shift direction encoding, shared with the single-step helper.
    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    // Control states of the sequential shifter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_shifter_shift1_step.sv
// shift1_step: combinational one-bit logical shift/rotate of a WIDTH-bit word.
// rot=1 re-inserts the bit shifted out; rot=0 zero-fills.
module shift1_step
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = SHIFTER_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             rot,
    output logic [WIDTH-1:0] next_data
);

    // One step in the requested direction; the vacated bit is the wrapped bit or zero.
    // NOTE: the output gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        next_data = data;
        if (dir == SHIFT_LEFT) begin
            next_data = {data[WIDTH-2:0], rot & data[WIDTH-1]};
        end else begin
            next_data = {rot & data[0], data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle shift unit, one bit per clock, valid/ready on both sides.
// Define SERIAL_SHIFTER_ROTATE_EN to add the in_rot port and rotate support;
// without it every shift zero-fills.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = SHIFTER_WIDTH,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
`ifdef SERIAL_SHIFTER_ROTATE_EN
    input  logic             in_rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_e           state;
    state_e           state_n;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_data;
    logic [AMT_W-1:0] cnt_q;
    logic             dir_q;
    logic             rot_q;
    logic             accept;

    shift1_step #(.WIDTH(WIDTH)) u_step (
        .data      (data_q),
        .dir       (dir_q),
        .rot       (rot_q),
        .next_data (step_data)
    );

`ifdef SERIAL_SHIFTER_ROTATE_EN
    // Rotate mode is captured at accept so later in_rot changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= in_rot;
        end
    end
`else
    assign rot_q = 1'b0;
`endif

    // Next-state and handshake outputs; in_valid is only looked at in IDLE.
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Result is presented only while DONE, so it is zero out of reset and never shows partial steps.
    assign out_data = (state == DONE) ? data_q : '0;

    // State register plus operand load on accept and one step per SHIFT cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            dir_q  <= SHIFT_LEFT;
        end else begin
            state <= state_n;
            if (accept) begin
                data_q <= in_data;
                dir_q  <= in_dir;
                cnt_q  <= in_amt;
            end else if (state == SHIFT) begin
                data_q <= step_data;
                cnt_q  <= cnt_q - AMT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: scoreboard bench for serial_shifter (default build; rotate
// cases are included when SERIAL_SHIFTER_ROTATE_EN is defined).
module tb_serial_shifter;

    localparam int W = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_dir = 1'b0;
    logic [AW-1:0] in_amt = '0;
    logic          in_rot = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    serial_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
`ifdef SERIAL_SHIFTER_ROTATE_EN
        .in_rot    (in_rot),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: repeated one-bit shifts written as a plain loop.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dir,
                                           input int amt, input logic rot);
        logic [W-1:0] r;
        logic b;
        r = d;
        for (int i = 0; i < amt; i++) begin
            if (!dir) begin
                b = r[W-1];
                r = r << 1;
                if (rot) r[0] = b;
            end else begin
                b = r[0];
                r = r >> 1;
                if (rot) r[W-1] = b;
            end
        end
        return r;
    endfunction

    // One full transaction: accept, latency, result, optional backpressure / DONE poke.
    task automatic do_op(input string tag, input logic [W-1:0] d, input logic dir,
                         input int amt, input logic rot, input logic [W-1:0] exp,
                         input int hold, input logic poke);
        int cycles;
        logic ready_low;
        logic [W-1:0] want;
        exp_q.push_back(exp);
        cycles = 0;
        while (!in_ready && cycles < 100) begin
            tick();
            cycles++;
        end
        check({tag, " in_ready"}, W'(in_ready), W'(1));
        out_ready = (hold == 0);
        in_valid = 1'b1;
        in_data = d;
        in_dir = dir;
        in_amt = AW'(amt);
        in_rot = rot;
        tick();
        // Scramble inputs after accept; they must have no effect.
        in_valid = poke;
        in_data = ~d;
        in_dir = ~dir;
        in_amt = ~AW'(amt);
        in_rot = ~rot;
        cycles = 0;
        ready_low = 1'b1;
        while (!out_valid && cycles < 100) begin
            if (in_ready || !busy) ready_low = 1'b0;
            tick();
            cycles++;
        end
        check({tag, " latency"}, W'(cycles), W'(amt));
        check({tag, " busy_no_ready"}, W'(ready_low && busy && !in_ready), W'(1));
        want = exp_q.pop_front();
        check({tag, " data"}, out_data, want);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_valid"}, W'(out_valid), W'(1));
            check({tag, " hold_data"}, out_data, want);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " ready_after"}, W'(in_ready), W'(1));
        check({tag, " valid_after"}, W'(out_valid), W'(0));
        check({tag, " idle_not_busy"}, W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] rd;
        logic rdir;
        int ramt;
        int cycles;
        logic stale;

        #12;
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset out_data", out_data, '0);
        check("reset busy", W'(busy), W'(0));
        #3 rst_n = 1'b1;
        #3;

        do_op("left1", 32'd9, 1'b0, 1, 1'b0, 32'd18, 0, 1'b0);
        do_op("right2", 32'd5, 1'b1, 2, 1'b0, 32'd1, 0, 1'b0);
        do_op("amt0", 32'h9EAB_389A, 1'b0, 0, 1'b0, 32'h9EAB_389A, 0, 1'b1);
        do_op("bp", 32'hD2A3_3B98, 1'b0, 4, 1'b0, 32'h2A33_B980, 5, 1'b1);
        do_op("max_left", 32'hFFFF_FFFF, 1'b0, 31, 1'b0, 32'h8000_0000, 0, 1'b0);
        do_op("max_right", 32'hFFFF_FFFF, 1'b1, 31, 1'b0, 32'h0000_0001, 0, 1'b0);
        // Rotate request is ignored in the zero-fill build.
`ifndef SERIAL_SHIFTER_ROTATE_EN
        do_op("norot", 32'h8000_0001, 1'b0, 1, 1'b1, 32'h0000_0002, 0, 1'b0);
`else
        do_op("rotl", 32'h8000_0001, 1'b0, 1, 1'b1, 32'h0000_0003, 0, 1'b0);
        do_op("rotr", 32'h8000_0001, 1'b1, 1, 1'b1, 32'hC000_0000, 0, 1'b0);
        do_op("rotl_z", 32'h8000_0001, 1'b0, 1, 1'b0, 32'h0000_0002, 0, 1'b0);
`endif

        for (int k = 0; k < 8; k++) begin
            rd = $urandom;
            rdir = 1'($urandom_range(0, 1));
            ramt = $urandom_range(0, W - 1);
            do_op("rand", rd, rdir, ramt, 1'b0, model(rd, rdir, ramt, 1'b0), k % 3, 1'b0);
        end

        // Reset in the middle of a long shift: operation is dropped.
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        in_dir = 1'b0;
        in_amt = AW'(20);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("mid busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("rst in_ready", W'(in_ready), W'(1));
        check("rst out_valid", W'(out_valid), W'(0));
        check("rst out_data", out_data, '0);
        check("rst busy", W'(busy), W'(0));
        #3 rst_n = 1'b1;
        stale = 1'b0;
        cycles = 0;
        while (cycles < 30) begin
            tick();
            if (out_valid || busy) stale = 1'b1;
            cycles++;
        end
        check("no stale result", W'(stale), W'(0));
        do_op("post_rst", 32'h0000_00F0, 1'b1, 4, 1'b0, 32'h0000_000F, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_shifter.md
# serial_shifter

Multi-cycle 32-bit shift unit that shifts an accepted operand one bit per clock, left or right, by a programmable amount (0..WIDTH-1). It uses a valid/ready handshake on input and output. It sits directly downstream of the address/operand source and upstream of any consumer of shifted addresses. It replaces single-step shift-by-1 calls with a reusable, amount-driven sequential stage.

## Interface
- WIDTH, 32, operand width in bits.
- AMT_W, $clog2(WIDTH), shift-amount width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- in_data  input  WIDTH  operand.
- in_dir  input  1  direction: 1'b0 = left, 1'b1 = right.
- in_amt  input  AMT_W  number of one-bit steps.
- in_rot  input  1  rotate instead of zero-fill. Present only with SERIAL_SHIFTER_ROTATE_EN.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

## Operation
- **State machine: IDLE, SHIFT, DONE.**
- **IDLE:**
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch in_data into the data register, latch in_dir, latch in_rot, and load the counter with in_amt.
  - If in_amt==0, go to DONE. Otherwise go to SHIFT.
- **SHIFT:** each edge performs one one-bit step and decrements the counter.
  - Left step: data<<1, with LSB=0.
  - Right step: data>>1, with MSB=0.
  - When the step is taken with counter==1, go to DONE.
- **DONE:**
  - out_valid=1 and out_data=data register.
  - On out_valid && out_ready at an edge, go to IDLE.
- **No same-cycle re-accept.** in_ready rises the cycle after the output handshake.
- **Input sampling.** Inputs are sampled only at the accept edge. Changes to in_* after acceptance have no effect.
- **Output stability.** out_data is stable for the whole DONE residency.
- **Arithmetic.** Logical shifts only. Bits shifted out are discarded, unless rotate is enabled per Configuration.
- **Amount range.** in_amt values are 0..WIDTH-1. The maximum amount yields a single surviving bit.

## Timing
- **Reset values (async assert, any state, including mid-SHIFT):**
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_data=0, counter=0.
  - The operation in flight is dropped with no output.
- **Reset release:** IDLE; the first accept is possible at the first clock edge after deassertion.
- **Latency:** with the accept at edge t, out_valid is high in the cycle after edge t+in_amt. So amt=0 gives out_valid in the cycle after the accept edge.
- **Throughput:** one operation per in_amt+2 cycles with out_ready held high.
- **Backpressure:** out_ready low holds DONE indefinitely, with out_valid and out_data unchanged.
- **in_valid outside IDLE:** ignored. No accept, and no side effects.

## Configuration
- **Macro:** SERIAL_SHIFTER_ROTATE_EN.
- **Defined:**
  - The in_rot port exists.
  - When the latched rot==1, each step re-inserts the bit shifted out. Left feeds the MSB into the LSB; right feeds the LSB into the MSB.
  - When rot==0, the unit zero-fills.
- **Undefined:** the in_rot port is absent and all shifts zero-fill. Behaviour is otherwise identical.

## Structure
- **Package serial_shifter_pkg holds:**
  - the direction constants SHIFT_LEFT=1'b0 and SHIFT_RIGHT=1'b1;
  - the state enum (IDLE, SHIFT, DONE);
  - the default WIDTH.
- **Sub-module shift1_step:**
  - Purely combinational single-bit step with inputs data, dir and rot, and the next data as output.
  - The FSM instantiates it once.
  - It is independently testable against the shift-by-1 semantics used elsewhere in the codebase.

## Test plan
- **Left shift, amt=1:** in_data=32'd9, dir=0, amt=1 → out_data=32'd18. out_valid is high in the cycle after accept edge +1.
- **Right shift, amt=2:** in_data=32'd5, dir=1, amt=2 → out_data=32'd1 after 2 shift cycles. in_ready is low throughout.
- **Zero amount:** in_data=32'h9EAB_389A, amt=0 → out_data=32'h9EAB_389A with out_valid in the cycle after accept. A second in_valid during DONE is not accepted.
- **Backpressure, then new operand:**
  - in_data=32'hD2A3_3B98, dir=0, amt=4 → out_data=32'h2A33_B980.
  - Hold out_ready=0 for 5 cycles → out_valid and out_data are stable.
  - Release out_ready → in_ready=1 on the next cycle.
- **Reset mid-shift:** rst_n low during SHIFT with amt=20 → immediately in_ready=1, out_valid=0, out_data=0. No stale result appears after release.
- **Rotate, with SERIAL_SHIFTER_ROTATE_EN only:**
  - 32'h8000_0001, dir=0, rot=1, amt=1 → 32'h0000_0003.
  - Same operand, dir=1, rot=1, amt=1 → 32'hC000_0000.
